// File: rtl/color_sensor_filter_pkg.sv
// Shared color codes and FSM state type for the cube color sensing path.
// determine_state and the solver use the same color encoding.
package color_sensor_filter_pkg;

    localparam logic [2:0] ColorW       = 3'd0;
    localparam logic [2:0] ColorO       = 3'd1;
    localparam logic [2:0] ColorG       = 3'd2;
    localparam logic [2:0] ColorRed     = 3'd3;
    localparam logic [2:0] ColorBlue    = 3'd4;
    localparam logic [2:0] ColorY       = 3'd5;
    localparam logic [2:0] ColorUnknown = 3'd7;

    typedef enum logic [1:0] {
        StBusy,
        StSettle,
        StSample,
        StStable
    } state_e;

    // Largest of three unsigned 8-bit channels.
    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/color_sensor_filter_rgb_classifier.sv
// Combinational RGB -> sticker color classifier. The first matching rule wins.
module color_sensor_filter_rgb_classifier
    import color_sensor_filter_pkg::*;
(
    input  logic [23:0] i_rgb,
    input  logic [7:0]  i_white_min,
    input  logic [7:0]  i_hi,
    input  logic [7:0]  i_mid,
    input  logic [7:0]  i_dark_max,
    output logic [2:0]  o_color
);

    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;
    logic [7:0] w_max;

    assign w_r   = i_rgb[23:16];
    assign w_g   = i_rgb[15:8];
    assign w_b   = i_rgb[7:0];
    assign w_max = max3(w_r, w_g, w_b);

    // Ordered threshold chain; a dark reading means no sticker under the sensor.
    always_comb begin
        o_color = ColorUnknown;
        if (w_max < i_dark_max) begin
            o_color = ColorUnknown;
        end else if (w_r >= i_white_min && w_g >= i_white_min && w_b >= i_white_min) begin
            o_color = ColorW;
        end else if (w_r >= i_hi && w_g >= i_hi) begin
            o_color = ColorY;
        end else if (w_r >= i_hi && w_g >= i_mid) begin
            o_color = ColorO;
        end else if (w_r >= i_hi) begin
            o_color = ColorRed;
        end else if (w_g >= w_b) begin
            o_color = ColorG;
        end else begin
            o_color = ColorBlue;
        end
    end

endmodule

// File: rtl/color_sensor_filter.sv
// Settles after each move, debounces edge/corner classifications and presents a stable color
// pair to determine_state. A timeout releases a stuck position with the last seen candidates.
module color_sensor_filter
    import color_sensor_filter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 250000,
    parameter int unsigned MATCH_COUNT    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  WHITE_MIN      = 8'd180,
    parameter logic [7:0]  HI             = 8'd140,
    parameter logic [7:0]  MID            = 8'd70,
    parameter logic [7:0]  DARK_MAX       = 8'd30
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_send_setup_moves,
    input  logic        i_motors_done,
    input  logic        i_sample_valid,
    input  logic [23:0] i_edge_rgb,
    input  logic [23:0] i_corner_rgb,
    output logic [2:0]  o_edge_color_sensor,
    output logic [2:0]  o_corner_color_sensor,
    output logic        o_color_sensor_stable,
    output logic        o_timeout_flag
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned ToW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SettleW-1:0] SettleMax  = SettleW'(SETTLE_CYCLES);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [MatchW-1:0]  MatchMax   = MatchW'(MATCH_COUNT);
    localparam logic [ToW-1:0]     ToMax      = ToW'(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0]     ToLast     = ToW'(TIMEOUT_CYCLES - 1);

    state_e               r_state;
    state_e               w_state_d;
    logic [SettleW-1:0]   r_settle_cnt;
    logic [SettleW-1:0]   w_settle_cnt_d;
    logic [MatchW-1:0]    r_match_cnt;
    logic [MatchW-1:0]    w_match_cnt_d;
    logic [ToW-1:0]       r_to_cnt;
    logic [ToW-1:0]       w_to_cnt_d;
    logic [2:0]           r_cand_edge;
    logic [2:0]           w_cand_edge_d;
    logic [2:0]           r_cand_corner;
    logic [2:0]           w_cand_corner_d;
    logic                 r_cand_valid;
    logic                 w_cand_valid_d;
    logic [2:0]           r_edge_color;
    logic [2:0]           w_edge_color_d;
    logic [2:0]           r_corner_color;
    logic [2:0]           w_corner_color_d;
    logic                 r_stable;
    logic                 w_stable_d;
    logic                 r_timeout_flag;
    logic                 w_timeout_flag_d;

    logic [2:0]           w_edge_class;
    logic [2:0]           w_corner_class;

    color_sensor_filter_rgb_classifier u_edge_classifier (
        .i_rgb       (i_edge_rgb),
        .i_white_min (WHITE_MIN),
        .i_hi        (HI),
        .i_mid       (MID),
        .i_dark_max  (DARK_MAX),
        .o_color     (w_edge_class)
    );

    color_sensor_filter_rgb_classifier u_corner_classifier (
        .i_rgb       (i_corner_rgb),
        .i_white_min (WHITE_MIN),
        .i_hi        (HI),
        .i_mid       (MID),
        .i_dark_max  (DARK_MAX),
        .o_color     (w_corner_class)
    );

    // Next-state, counters, candidate tracking and output latch.
    always_comb begin
        w_state_d        = r_state;
        w_settle_cnt_d   = r_settle_cnt;
        w_match_cnt_d    = r_match_cnt;
        w_to_cnt_d       = r_to_cnt;
        w_cand_edge_d    = r_cand_edge;
        w_cand_corner_d  = r_cand_corner;
        w_cand_valid_d   = r_cand_valid;
        w_edge_color_d   = r_edge_color;
        w_corner_color_d = r_corner_color;
        w_stable_d       = r_stable;
        w_timeout_flag_d = r_timeout_flag;

        unique case (r_state)
            StBusy: begin
                if (i_motors_done) begin
                    w_state_d      = StSettle;
                    w_settle_cnt_d = '0;
                end
            end
            StSettle: begin
                if (r_settle_cnt == SettleLast) begin
                    w_state_d      = StSample;
                    w_match_cnt_d  = '0;
                    w_to_cnt_d     = '0;
                    // Candidates from the previous position must not count here.
                    w_cand_valid_d = 1'b0;
                end else if (r_settle_cnt != SettleMax) begin
                    w_settle_cnt_d = r_settle_cnt + 1'b1;
                end
            end
            StSample: begin
                if (r_to_cnt != ToMax) begin
                    w_to_cnt_d = r_to_cnt + 1'b1;
                end
                if (i_sample_valid) begin
                    if (w_edge_class == ColorUnknown || w_corner_class == ColorUnknown) begin
                        w_match_cnt_d = '0;
                    end else if (r_cand_valid && w_edge_class == r_cand_edge &&
                                 w_corner_class == r_cand_corner) begin
                        if (r_match_cnt != MatchMax) begin
                            w_match_cnt_d = r_match_cnt + 1'b1;
                        end
                    end else begin
                        w_cand_edge_d   = w_edge_class;
                        w_cand_corner_d = w_corner_class;
                        w_cand_valid_d  = 1'b1;
                        w_match_cnt_d   = MatchW'(1);
                    end
                end
                if (w_match_cnt_d == MatchMax) begin
                    w_edge_color_d   = w_cand_edge_d;
                    w_corner_color_d = w_cand_corner_d;
                    w_stable_d       = 1'b1;
                    w_state_d        = StStable;
                end else if (r_to_cnt == ToLast) begin
                    w_edge_color_d   = w_cand_valid_d ? w_cand_edge_d : ColorUnknown;
                    w_corner_color_d = w_cand_valid_d ? w_cand_corner_d : ColorUnknown;
                    w_timeout_flag_d = 1'b1;
                    w_stable_d       = 1'b1;
                    w_state_d        = StStable;
                end
            end
            StStable: begin
                w_stable_d = 1'b1;
            end
            default: begin
                w_state_d = StBusy;
            end
        endcase

        // A new move sequence overrides everything decided above this cycle.
        if (i_send_setup_moves) begin
            w_state_d        = StBusy;
            w_stable_d       = 1'b0;
            w_edge_color_d   = r_edge_color;
            w_corner_color_d = r_corner_color;
            w_timeout_flag_d = r_timeout_flag;
        end
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= StBusy;
            r_settle_cnt   <= '0;
            r_match_cnt    <= '0;
            r_to_cnt       <= '0;
            r_cand_edge    <= '0;
            r_cand_corner  <= '0;
            r_cand_valid   <= 1'b0;
            r_edge_color   <= '0;
            r_corner_color <= '0;
            r_stable       <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_settle_cnt   <= w_settle_cnt_d;
            r_match_cnt    <= w_match_cnt_d;
            r_to_cnt       <= w_to_cnt_d;
            r_cand_edge    <= w_cand_edge_d;
            r_cand_corner  <= w_cand_corner_d;
            r_cand_valid   <= w_cand_valid_d;
            r_edge_color   <= w_edge_color_d;
            r_corner_color <= w_corner_color_d;
            r_stable       <= w_stable_d;
            r_timeout_flag <= w_timeout_flag_d;
        end
    end

    // Stable drops in the very cycle a new move sequence is announced.
    assign o_color_sensor_stable = r_stable & ~i_send_setup_moves;
    assign o_edge_color_sensor   = r_edge_color;
    assign o_corner_color_sensor = r_corner_color;
    assign o_timeout_flag        = r_timeout_flag;

endmodule

// File: tb/tb_color_sensor_filter.sv
// Self-checking bench for color_sensor_filter with short settle/match/timeout parameters.
module tb_color_sensor_filter;

    localparam int Settle  = 10;
    localparam int Match   = 4;
    localparam int Timeout = 50;

    logic        clk;
    logic        i_reset_n;
    logic        i_send_setup_moves;
    logic        i_motors_done;
    logic        i_sample_valid;
    logic [23:0] i_edge_rgb;
    logic [23:0] i_corner_rgb;
    logic [2:0]  o_edge;
    logic [2:0]  o_corner;
    logic        o_stable;
    logic        o_timeout;

    color_sensor_filter #(
        .SETTLE_CYCLES  (Settle),
        .MATCH_COUNT    (Match),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .i_clock               (clk),
        .i_reset_n             (i_reset_n),
        .i_send_setup_moves    (i_send_setup_moves),
        .i_motors_done         (i_motors_done),
        .i_sample_valid        (i_sample_valid),
        .i_edge_rgb            (i_edge_rgb),
        .i_corner_rgb          (i_corner_rgb),
        .o_edge_color_sensor   (o_edge),
        .o_corner_color_sensor (o_corner),
        .o_color_sensor_stable (o_stable),
        .o_timeout_flag        (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [23:0] e;
        logic [23:0] c;
    } samp_t;

    typedef struct {
        logic [23:0] e;
        logic [23:0] c;
        logic [2:0]  exp_e;
        logic [2:0]  exp_c;
    } vec_t;

    samp_t       q[$];
    vec_t        vecs[7];
    logic [23:0] pal[6];

    int n_checks = 0;
    int n_err    = 0;

    // Expected DUT-visible state carried across moves.
    logic [2:0] exp_edge;
    logic [2:0] exp_corner;
    logic       exp_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb(input int r, input int g, input int b);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Reference classifier straight from the color rules.
    function automatic logic [2:0] ref_class(input logic [23:0] v);
        int r;
        int g;
        int b;
        int mx;
        r  = int'(v[23:16]);
        g  = int'(v[15:8]);
        b  = int'(v[7:0]);
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (mx < 30) return 3'd7;
        if (r >= 180 && g >= 180 && b >= 180) return 3'd0;
        if (r >= 140 && g >= 140) return 3'd5;
        if (r >= 140 && g >= 70) return 3'd1;
        if (r >= 140) return 3'd3;
        if (g >= b) return 3'd2;
        return 3'd4;
    endfunction

    // Scan the queued samples (index 0 = first SAMPLE cycle) and predict the release.
    task automatic predict(output int rise, output logic [2:0] pe, output logic [2:0] pc,
                           output bit pto);
        int         run;
        bit         have;
        bit         done;
        logic [2:0] ce;
        logic [2:0] cc;
        logic [2:0] a;
        logic [2:0] b;
        run  = 0;
        have = 0;
        done = 0;
        ce   = 3'd0;
        cc   = 3'd0;
        rise = Timeout;
        pto  = 1'b1;
        for (int k = 0; k < Timeout && !done; k++) begin
            if (k < q.size() && q[k].valid) begin
                a = ref_class(q[k].e);
                b = ref_class(q[k].c);
                if (a == 3'd7 || b == 3'd7) begin
                    run = 0;
                end else if (have && a == ce && b == cc) begin
                    run++;
                end else begin
                    ce   = a;
                    cc   = b;
                    have = 1;
                    run  = 1;
                end
            end
            if (run == Match) begin
                rise = k + 1;
                pto  = 1'b0;
                done = 1;
            end
        end
        pe = have ? ce : 3'd7;
        pc = have ? cc : 3'd7;
    endtask

    task automatic drive_junk();
        i_sample_valid = 1'b1;
        i_edge_rgb     = 24'($urandom);
        i_corner_rgb   = 24'($urandom);
    endtask

    // One full move: setup pulse, motors_done, settle, then the queued samples.
    task automatic run_move(output int seen_k);
        int         rise;
        logic [2:0] pe;
        logic [2:0] pc;
        bit         pto;
        logic       to_after;
        predict(rise, pe, pc, pto);
        to_after = exp_to | pto;
        seen_k   = -1;

        i_send_setup_moves = 1'b1;
        @(negedge clk);
        check("stable_masked_by_setup", o_stable, 1'b0);
        check("edge_held_on_setup", o_edge, exp_edge);
        tick();
        i_send_setup_moves = 1'b0;
        drive_junk();
        @(negedge clk);
        check("stable_in_busy", o_stable, 1'b0);
        check("corner_held_in_busy", o_corner, exp_corner);
        tick();

        i_motors_done  = 1'b1;
        i_sample_valid = 1'b0;
        tick();
        i_motors_done = 1'b0;
        for (int s = 0; s < Settle; s++) begin
            drive_junk();
            i_motors_done = (s == 3);
            @(negedge clk);
            check("stable_in_settle", o_stable, 1'b0);
            tick();
        end
        i_motors_done = 1'b0;

        for (int k = 0; k <= Timeout + 2; k++) begin
            if (k < q.size()) begin
                i_sample_valid = q[k].valid;
                i_edge_rgb     = q[k].e;
                i_corner_rgb   = q[k].c;
            end else begin
                i_sample_valid = 1'b0;
            end
            i_motors_done = (k == 1);
            @(negedge clk);
            if (seen_k < 0 && o_stable === 1'b1) seen_k = k;
            check("stable", o_stable, (k >= rise));
            check("edge_color", o_edge, (k >= rise) ? pe : exp_edge);
            check("corner_color", o_corner, (k >= rise) ? pc : exp_corner);
            check("timeout_flag", o_timeout, (k >= rise) ? to_after : exp_to);
            tick();
        end
        i_motors_done  = 1'b0;
        i_sample_valid = 1'b0;
        exp_edge       = pe;
        exp_corner     = pc;
        exp_to         = to_after;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stable"}, o_stable, 1'b0);
        check({tag, "_edge"}, o_edge, 3'd0);
        check({tag, "_corner"}, o_corner, 3'd0);
        check({tag, "_timeout"}, o_timeout, 1'b0);
    endtask

    // Drive valid samples with no motors_done; nothing may be released.
    task automatic idle_with_samples(input string tag);
        for (int k = 0; k < Settle + Match + 10; k++) begin
            i_sample_valid = 1'b1;
            i_edge_rgb     = pal[3];
            i_corner_rgb   = pal[0];
            @(negedge clk);
            check(tag, o_stable, 1'b0);
            tick();
        end
        i_sample_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        i_reset_n = 1'b0;
        tick();
        i_reset_n  = 1'b1;
        exp_edge   = 3'd0;
        exp_corner = 3'd0;
        exp_to     = 1'b0;
    endtask

    initial begin
        int         seen;
        int         base;
        int         r;
        samp_t      s;

        pal[0] = rgb(200, 200, 200);
        pal[1] = rgb(200, 100, 20);
        pal[2] = rgb(20, 150, 60);
        pal[3] = rgb(200, 20, 20);
        pal[4] = rgb(20, 60, 150);
        pal[5] = rgb(200, 200, 40);

        vecs[0] = '{rgb(200, 200, 200), rgb(200, 20, 20),   3'd0, 3'd3};
        vecs[1] = '{rgb(200, 200, 40),  rgb(20, 150, 60),   3'd5, 3'd2};
        vecs[2] = '{rgb(200, 100, 20),  rgb(20, 60, 150),   3'd1, 3'd4};
        vecs[3] = '{rgb(200, 20, 20),   rgb(200, 200, 200), 3'd3, 3'd0};
        vecs[4] = '{rgb(20, 150, 60),   rgb(200, 200, 40),  3'd2, 3'd5};
        vecs[5] = '{rgb(20, 60, 150),   rgb(200, 100, 20),  3'd4, 3'd1};
        vecs[6] = '{rgb(10, 10, 10),    rgb(200, 200, 200), 3'd7, 3'd7};

        i_reset_n          = 1'b0;
        i_send_setup_moves = 1'b0;
        i_motors_done      = 1'b0;
        i_sample_valid     = 1'b0;
        i_edge_rgb         = '0;
        i_corner_rgb       = '0;
        exp_edge           = 3'd0;
        exp_corner         = 3'd0;
        exp_to             = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Classification sweep with steady samples; steady Red/W also gives the latency check.
        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int k = 0; k < Timeout; k++) q.push_back('{1'b1, vecs[i].e, vecs[i].c});
            run_move(seen);
            check("table_edge", o_edge, vecs[i].exp_e);
            check("table_corner", o_corner, vecs[i].exp_c);
            if (i < 6) check("latency", Settle + 1 + seen, Settle + Match + 1);
            else check("unknown_timeout_release", seen, Timeout);
        end
        check("unknown_sets_timeout_flag", o_timeout, 1'b1);

        // Reset while stable clears colors and the sticky flag.
        pulse_reset();
        @(negedge clk);
        check_all_zero("reset_in_stable");
        idle_with_samples("no_release_after_stable_reset");

        // Noise: the O sample restarts the run.
        q.delete();
        q.push_back('{1'b1, pal[3], pal[0]});
        q.push_back('{1'b1, pal[3], pal[0]});
        q.push_back('{1'b1, pal[1], pal[0]});
        for (int k = 0; k < 4; k++) q.push_back('{1'b1, pal[3], pal[0]});
        run_move(seen);
        check("noise_release_cycle", seen, 7);
        check("noise_edge", o_edge, 3'd3);
        check("noise_corner", o_corner, 3'd0);

        // Alternating G/Blue never matches and times out with the last candidate.
        q.delete();
        for (int k = 0; k < Timeout; k++) q.push_back('{1'b1, (k % 2 == 0) ? pal[2] : pal[4], pal[0]});
        run_move(seen);
        check("alt_timeout_cycle", seen, Timeout);
        check("alt_edge", o_edge, 3'd4);
        check("alt_corner", o_corner, 3'd0);
        check("alt_flag", o_timeout, 1'b1);

        // Randomized moves against the model; the timeout flag must persist.
        for (int m = 0; m < 10; m++) begin
            q.delete();
            base = int'($urandom_range(0, 5));
            for (int k = 0; k < Timeout; k++) begin
                r       = int'($urandom_range(0, 15));
                s.valid = (r > 1);
                s.e     = pal[base];
                s.c     = pal[(base + 2) % 6];
                if (r == 2) s.e = 24'($urandom);
                if (r == 3) s.c = 24'($urandom);
                if (r == 4) s.e = rgb(5, 20, 12);
                q.push_back(s);
            end
            run_move(seen);
        end
        check("flag_sticky_after_moves", o_timeout, 1'b1);

        // Reset during SETTLE: outputs clear and a new motors_done is required.
        i_send_setup_moves = 1'b1;
        tick();
        i_send_setup_moves = 1'b0;
        i_motors_done      = 1'b1;
        tick();
        i_motors_done = 1'b0;
        tick();
        tick();
        tick();
        pulse_reset();
        @(negedge clk);
        check_all_zero("reset_in_settle");
        idle_with_samples("no_release_after_settle_reset");

        q.delete();
        for (int k = 0; k < Timeout; k++) q.push_back('{1'b1, pal[5], pal[1]});
        run_move(seen);
        check("recover_edge", o_edge, 3'd5);
        check("recover_corner", o_corner, 3'd1);
        check("recover_flag", o_timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
